// File: rtl/gift_pkg.sv
// Shared types and constants for the GIFT encryption-core arbiter.
package gift_pkg;

   localparam int unsigned GIFT_BLK_W       = 128;
   localparam int unsigned GIFT_TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_BUSY,
      ST_RUN,
      ST_RESP
   } gift_state_e;

   typedef struct packed {
      logic [GIFT_BLK_W-1:0] key;
      logic [GIFT_BLK_W-1:0] data;
   } gift_req_t;

   function automatic logic [1:0] gift_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/gift_rr_arb2.sv
// Two-input round-robin grant; the pointer names the winner of the next tie.
module gift_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt_c
);

   logic rr;

   always_comb begin
      gnt_c = req;
      if (req == 2'b11) begin
         gnt_c = rr ? 2'b10 : 2'b01;
      end
   end

   // Pointer moves away from the winner, and only when a grant is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr <= 1'b0;
      end else if (en && (gnt_c != 2'b00)) begin
         rr <= ~gnt_c[1];
      end
   end

endmodule

// File: rtl/gift_enc_arbiter.sv
// Shares one GiftFullEnc core between two requesters: arbitrate, load the core,
// wait for completion under a watchdog, and return the ciphertext to the owner.
module gift_enc_arbiter
   import gift_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = GIFT_TIMEOUT_DEF,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                    inClk,
   input  logic                    inRst,
   input  logic [1:0]              inReqValid,
   input  logic [2*GIFT_BLK_W-1:0] inReqKey,
   input  logic [2*GIFT_BLK_W-1:0] inReqData,
   output logic [1:0]              outReqReady,
   output logic [1:0]              outRspValid,
   input  logic [1:0]              inRspReady,
   output logic [GIFT_BLK_W-1:0]   outRspData,
   output logic                    outRspErr,
   output logic                    outErr,
   output logic [CNT_W-1:0]        outDoneCnt,
   output logic                    outCoreKeyWr,
   output logic                    outCoreDataWr,
   output logic [GIFT_BLK_W-1:0]   outCoreKey,
   output logic [GIFT_BLK_W-1:0]   outCoreData,
   input  logic [GIFT_BLK_W-1:0]   inCoreData,
   input  logic                    inCoreBusy
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   gift_state_e     state;
   logic            owner;
   logic [WD_W-1:0] wd;
   logic [1:0]      gnt_c;
   logic            grant_en_c;
   gift_req_t       req_c;

   // The core has no reset, so a stale busy core blocks any new grant.
   assign grant_en_c  = (state == ST_IDLE) && !inCoreBusy;
   assign outReqReady = grant_en_c ? gnt_c : 2'b00;

   gift_rr_arb2 u_arb (
      .clk   (inClk),
      .rst   (inRst),
      .req   (inReqValid),
      .en    (grant_en_c),
      .gnt_c (gnt_c)
   );

   always_comb begin
      req_c = '0;
      if (gnt_c[1]) begin
         req_c.key  = inReqKey[2*GIFT_BLK_W-1:GIFT_BLK_W];
         req_c.data = inReqData[2*GIFT_BLK_W-1:GIFT_BLK_W];
      end else begin
         req_c.key  = inReqKey[GIFT_BLK_W-1:0];
         req_c.data = inReqData[GIFT_BLK_W-1:0];
      end
   end

   always_ff @(posedge inClk) begin
      if (inRst) begin
         state         <= ST_IDLE;
         owner         <= 1'b0;
         wd            <= '0;
         outCoreKeyWr  <= 1'b0;
         outCoreDataWr <= 1'b0;
         outCoreKey    <= '0;
         outCoreData   <= '0;
         outRspValid   <= 2'b00;
         outRspData    <= '0;
         outRspErr     <= 1'b0;
         outErr        <= 1'b0;
         outDoneCnt    <= '0;
      end else begin
         outCoreKeyWr  <= 1'b0;
         outCoreDataWr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_en_c && (gnt_c != 2'b00)) begin
                  owner         <= gnt_c[1];
                  outCoreKey    <= req_c.key;
                  outCoreData   <= req_c.data;
                  outCoreKeyWr  <= 1'b1;
                  outCoreDataWr <= 1'b1;
                  wd            <= '0;
                  state         <= ST_LOAD;
               end
            end
            // Watchdog runs from the strobe cycle onward.
            ST_LOAD: begin
               wd    <= wd + WD_W'(1);
               state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_RUN: begin
               wd <= wd + WD_W'(1);
               if ((state == ST_RUN) && !inCoreBusy) begin
                  outRspData  <= inCoreData;
                  outRspErr   <= 1'b0;
                  outRspValid <= gift_onehot(owner);
                  state       <= ST_RESP;
               end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  outRspData  <= '0;
                  outRspErr   <= 1'b1;
                  outErr      <= 1'b1;
                  outRspValid <= gift_onehot(owner);
                  state       <= ST_RESP;
               end else if ((state == ST_WAIT_BUSY) && inCoreBusy) begin
                  state <= ST_RUN;
               end
            end
            ST_RESP: begin
               if (inRspReady[owner]) begin
                  outRspValid <= 2'b00;
                  if (!outRspErr) begin
                     outDoneCnt <= outDoneCnt + CNT_W'(1);
                  end
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gift_enc_arbiter.sv
// Bench for gift_enc_arbiter with a behavioural stand-in for the GiftFullEnc core.
`timescale 1ns/1ps
module tb_gift_enc_arbiter;

   localparam int unsigned TO = 8;
   localparam int unsigned CW = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [255:0] req_key, req_data;
   logic [127:0] rsp_data, core_key, core_din;
   logic         rsp_err, err, key_wr, data_wr;
   logic [CW-1:0] done_cnt;
   logic [127:0] core_out  = '0;
   logic         core_busy = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // Model state
   int m_rr, m_cnt;
   logic m_err;

   // Core stand-in controls
   int stub_delay = 1;
   int stub_len   = 2;
   bit stub_never = 0;
   int pre_cnt = 0;
   int rem_cnt = 0;
   logic [127:0] cap_k = '0, cap_d = '0;

   always #5 clk = ~clk;

   gift_enc_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .inClk(clk), .inRst(rst),
      .inReqValid(req_valid), .inReqKey(req_key), .inReqData(req_data),
      .outReqReady(req_ready), .outRspValid(rsp_valid), .inRspReady(rsp_ready),
      .outRspData(rsp_data), .outRspErr(rsp_err), .outErr(err), .outDoneCnt(done_cnt),
      .outCoreKeyWr(key_wr), .outCoreDataWr(data_wr),
      .outCoreKey(core_key), .outCoreData(core_din),
      .inCoreData(core_out), .inCoreBusy(core_busy)
   );

   function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] d);
      return k ^ {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int model_grant(input logic [1:0] v, input int rr);
      if (v == 2'b11) return rr;
      return v[1] ? 1 : 0;
   endfunction

   // Core stand-in: busy rises stub_delay cycles after the strobe, lasts stub_len cycles.
   always @(posedge clk) begin
      if (key_wr && data_wr && !stub_never) begin
         cap_k   <= core_key;
         cap_d   <= core_din;
         rem_cnt <= stub_len;
         if (stub_delay <= 1) core_busy <= 1'b1;
         else pre_cnt <= stub_delay - 1;
      end else if (pre_cnt > 0) begin
         pre_cnt <= pre_cnt - 1;
         if (pre_cnt == 1) core_busy <= 1'b1;
      end else if (core_busy) begin
         rem_cnt <= rem_cnt - 1;
         if (rem_cnt == 1) begin
            core_busy <= 1'b0;
            core_out  <= ref_cipher(cap_k, cap_d);
         end
      end
   end

   // Issue a request and wait (bounded) until a response is presented.
   task automatic run_req(input logic [1:0] v, input logic [255:0] k, input logic [255:0] d,
                          output int g, output int lat, output bit ok);
      int n;
      ok = 1; g = -1; lat = 0;
      @(negedge clk);
      req_valid = v; req_key = k; req_data = d;
      #1;
      n = 0;
      while ((req_ready & req_valid) == 2'b00) begin
         @(negedge clk); #1; n++;
         if (n > 100) begin ok = 0; break; end
      end
      if (ok) g = req_ready[1] ? 1 : 0;
      @(negedge clk);
      req_valid = 2'b00;
      lat = 1;
      while (ok && rsp_valid == 2'b00) begin
         @(negedge clk); lat++;
         if (lat > 100) ok = 0;
      end
   endtask

   task automatic finish_rsp(input int owner);
      rsp_ready = 2'(1 << owner);
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      m_rr = 0; m_cnt = 0; m_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00; req_key = '0; req_data = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready, key_wr, data_wr, rsp_err, err} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b want 00000000", {rsp_valid, req_ready, key_wr, data_wr, rsp_err, err});
      end
      vectors++;
      if ({core_key, core_din} !== 256'h0) begin
         miscompares++; $display("FAIL reset_core_bus got %h/%h want 0", core_key, core_din);
      end
      vectors++;
      if (rsp_data !== 128'h0 || done_cnt !== CW'(0)) begin
         miscompares++; $display("FAIL reset_rsp got data %h cnt %0d want 0", rsp_data, done_cnt);
      end
      rst = 1'b0;
      m_rr = 0; m_cnt = 0; m_err = 1'b0;
   endtask

   task automatic test_single();
      int g, lat; bit ok;
      stub_delay = 1; stub_len = $urandom_range(1, 4);
      run_req(2'b01, '0, '0, g, lat, ok);
      vectors++;
      if (!ok || g != 0) begin miscompares++; $display("FAIL single_grant got %0d ok %0d want 0", g, ok); end
      vectors++;
      if (lat != stub_len + 3) begin miscompares++; $display("FAIL single_latency got %0d want %0d", lat, stub_len + 3); end
      vectors++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin
         miscompares++; $display("FAIL single_valid got %b err %b want 01 err 0", rsp_valid, rsp_err);
      end
      vectors++;
      if (rsp_data !== ref_cipher('0, '0)) begin
         miscompares++; $display("FAIL single_data got %h want %h", rsp_data, ref_cipher('0, '0));
      end
      finish_rsp(0);
      m_rr = 1; m_cnt++;
      vectors++;
      if (done_cnt !== CW'(m_cnt) || rsp_valid !== 2'b00) begin
         miscompares++; $display("FAIL single_cnt got %0d valid %b want %0d valid 00", done_cnt, rsp_valid, CW'(m_cnt));
      end
   endtask

   task automatic test_alternate();
      int g, lat, exp_g; bit ok;
      logic [127:0] kv;
      kv = 128'hfedcba9876543210fedcba9876543210;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         stub_delay = $urandom_range(1, 2); stub_len = $urandom_range(1, 4);
         exp_g = model_grant(2'b11, m_rr);
         run_req(2'b11, {kv, kv}, {kv, kv}, g, lat, ok);
         vectors++;
         if (!ok || g != exp_g || rsp_valid !== 2'(1 << exp_g)) begin
            miscompares++; $display("FAIL alt_grant[%0d] got %0d valid %b want %0d", i, g, rsp_valid, exp_g);
         end
         vectors++;
         if (rsp_data !== ref_cipher(kv, kv) || lat != 2 + stub_delay + stub_len) begin
            miscompares++;
            $display("FAIL alt_data[%0d] got %h lat %0d want %h lat %0d", i, rsp_data, lat, ref_cipher(kv, kv), 2 + stub_delay + stub_len);
         end
         finish_rsp(exp_g);
         m_rr = 1 - exp_g; m_cnt++;
      end
      vectors++;
      if (done_cnt !== CW'(m_cnt)) begin miscompares++; $display("FAIL alt_cnt got %0d want %0d", done_cnt, CW'(m_cnt)); end
   endtask

   task automatic test_backpressure();
      int g, lat, exp_g; bit ok;
      logic [127:0] k0, d0, hold_data;
      logic [1:0] hold_valid;
      k0 = rand128(); d0 = rand128();
      stub_delay = 1; stub_len = 3;
      exp_g = model_grant(2'b01, m_rr);
      run_req(2'b01, {rand128(), k0}, {rand128(), d0}, g, lat, ok);
      hold_valid = rsp_valid; hold_data = rsp_data;
      vectors++;
      if (!ok || g != exp_g || hold_data !== ref_cipher(k0, d0)) begin
         miscompares++; $display("FAIL bp_first got g %0d data %h want %0d %h", g, hold_data, exp_g, ref_cipher(k0, d0));
      end
      req_valid = 2'b11;
      rsp_ready = 2'b10;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         vectors++;
         if (rsp_valid !== 2'b01 || rsp_data !== hold_data || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_hold[%0d] got valid %b data %h ready %b want 01 %h 00", i, rsp_valid, rsp_data, req_ready, hold_data);
         end
      end
      req_valid = 2'b00; rsp_ready = 2'b00;
      finish_rsp(0);
      m_rr = 1; m_cnt++;
      vectors++;
      if (done_cnt !== CW'(m_cnt) || rsp_valid !== 2'b00) begin
         miscompares++; $display("FAIL bp_release got cnt %0d valid %b want %0d 00", done_cnt, rsp_valid, CW'(m_cnt));
      end
   endtask

   task automatic test_timeout();
      int g, lat, exp_g; bit ok;
      stub_never = 1;
      exp_g = model_grant(2'b10, m_rr);
      run_req(2'b10, {rand128(), rand128()}, {rand128(), rand128()}, g, lat, ok);
      vectors++;
      if (!ok || g != exp_g || lat != TO + 1) begin
         miscompares++; $display("FAIL timeout_latency got g %0d lat %0d want %0d lat %0d", g, lat, exp_g, TO + 1);
      end
      vectors++;
      if (rsp_err !== 1'b1 || rsp_data !== 128'h0 || err !== 1'b1 || rsp_valid !== 2'b10) begin
         miscompares++;
         $display("FAIL timeout_rsp got err %b data %h sticky %b valid %b want 1 0 1 10", rsp_err, rsp_data, err, rsp_valid);
      end
      finish_rsp(exp_g);
      m_rr = 1 - exp_g; m_err = 1'b1;
      vectors++;
      if (done_cnt !== CW'(m_cnt)) begin miscompares++; $display("FAIL timeout_cnt got %0d want %0d", done_cnt, CW'(m_cnt)); end
      stub_never = 0;
   endtask

   task automatic test_random();
      int g, lat, exp_g; bit ok;
      logic [1:0] v;
      logic [255:0] k, d;
      logic [127:0] exp_d;
      for (int i = 0; i < 12; i++) begin
         v = 2'($urandom_range(1, 3));
         k = {rand128(), rand128()}; d = {rand128(), rand128()};
         stub_delay = $urandom_range(1, 2); stub_len = $urandom_range(1, 4);
         exp_g = model_grant(v, m_rr);
         exp_d = (exp_g == 1) ? ref_cipher(k[255:128], d[255:128]) : ref_cipher(k[127:0], d[127:0]);
         run_req(v, k, d, g, lat, ok);
         vectors++;
         if (!ok || g != exp_g || rsp_data !== exp_d || lat != 2 + stub_delay + stub_len) begin
            miscompares++;
            $display("FAIL rand[%0d] got g %0d data %h lat %0d want %0d %h %0d", i, g, rsp_data, lat, exp_g, exp_d, 2 + stub_delay + stub_len);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         finish_rsp(exp_g);
         m_rr = 1 - exp_g; m_cnt++;
         vectors++;
         if (done_cnt !== CW'(m_cnt) || err !== m_err) begin
            miscompares++; $display("FAIL rand_cnt[%0d] got %0d err %b want %0d %b", i, done_cnt, err, CW'(m_cnt), m_err);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n, g, lat; bit ok, hold_ok;
      logic [127:0] nk, nd;
      stub_delay = 1; stub_len = 20;
      @(negedge clk);
      req_valid = 2'b01; req_key = {rand128(), rand128()}; req_data = {rand128(), rand128()};
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
      vectors++;
      if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rmid_accept got %b want 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      m_rr = 0; m_cnt = 0; m_err = 1'b0;
      vectors++;
      if ({rsp_valid, key_wr, data_wr, rsp_err, err} !== 6'h00 || done_cnt !== CW'(0) || core_key !== 128'h0) begin
         miscompares++;
         $display("FAIL rmid_reset got valid %b wr %b%b err %b%b cnt %0d key %h want zeros", rsp_valid, key_wr, data_wr, rsp_err, err, done_cnt, core_key);
      end
      req_valid = 2'b01;
      n = 0; hold_ok = 1;
      while (core_busy && n < 60) begin
         if (req_ready !== 2'b00) hold_ok = 0;
         @(negedge clk); #1; n++;
      end
      req_valid = 2'b00;
      vectors++;
      if (!hold_ok || core_busy) begin
         miscompares++; $display("FAIL rmid_no_grant got hold_ok %0d busy %b want 1 0", hold_ok, core_busy);
      end
      nk = rand128(); nd = rand128();
      stub_len = 2;
      run_req(2'b01, {rand128(), nk}, {rand128(), nd}, g, lat, ok);
      vectors++;
      if (!ok || g != 0 || rsp_data !== ref_cipher(nk, nd) || lat != 5) begin
         miscompares++; $display("FAIL rmid_after got g %0d data %h lat %0d want 0 %h 5", g, rsp_data, lat, ref_cipher(nk, nd));
      end
      finish_rsp(0);
      m_rr = 1; m_cnt++;
   endtask

   task automatic test_wrap();
      int g, lat, exp_g; bit ok;
      int exp_cnt[5] = '{1, 2, 3, 0, 1};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         stub_delay = 1; stub_len = $urandom_range(1, 3);
         exp_g = model_grant(2'b11, m_rr);
         run_req(2'b11, {rand128(), rand128()}, {rand128(), rand128()}, g, lat, ok);
         finish_rsp(exp_g);
         m_rr = 1 - exp_g;
         vectors++;
         if (!ok || done_cnt !== CW'(exp_cnt[i])) begin
            miscompares++; $display("FAIL wrap[%0d] got %0d want %0d", i, done_cnt, exp_cnt[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_timeout();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gift_enc_arbiter.md
# gift_enc_arbiter

Round-robin controller that shares one `GiftFullEnc` core between two requesters. Each requester issues a key/plaintext pair over a valid/ready handshake. The block captures the winning request, sequences the core's write strobes, and waits for `outBusy` to complete. It then returns the ciphertext to the owning requester over a response handshake, with a watchdog and a completion counter.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting on the core before the operation is aborted with an error.
- `CNT_W`, 16: width of the completion counter.

Ports:
- `inClk`  in  1  clock; all logic on the rising edge.
- `inRst`  in  1  reset, synchronous, active-high.
- `inReqValid`  in  2  per-requester request valid.
- `inReqKey`  in  256  two 128-bit keys; requester i uses bits [128i+127:128i].
- `inReqData`  in  256  two 128-bit plaintexts; same packing as `inReqKey`.
- `outReqReady`  out  2  one-hot; request accepted on `inReqValid[i] & outReqReady[i]`.
- `outRspValid`  out  2  one-hot; response valid for requester i.
- `inRspReady`  in  2  per-requester response ready.
- `outRspData`  out  128  ciphertext, shared by both requesters.
- `outRspErr`  out  1  qualifies `outRspData`; 1 means timeout and data is all-zero.
- `outErr`  out  1  sticky timeout flag; cleared only by reset.
- `outDoneCnt`  out  `CNT_W`  count of successful (non-error) responses; wraps.
- `outCoreKeyWr`, `outCoreDataWr`  out  1  strobes to core `inKeyWr` / `inDataWr`.
- `outCoreKey`, `outCoreData`  out  128  to core `inKeyData` / `inDataData`.
- `inCoreData`  in  128  from core `outData`.
- `inCoreBusy`  in  1  from core `outBusy`.

## Operation
- Core contract:
  - Strobes are asserted together for one cycle with key and data valid.
  - The core raises `outBusy` within 2 cycles of the strobe.
  - `outData` is valid and stable once `outBusy` falls.
- FSM with states IDLE, LOAD, WAIT_BUSY, RUN, RESP.
- **IDLE:** the grant requires `inCoreBusy == 0`.
  - If any `inReqValid` is set, grant one requester: pointer `rr` wins on a tie, otherwise the single valid one wins.
  - Assert `outReqReady[g]` combinationally this cycle.
  - Capture key, data and owner `g`; set `rr <= ~g`; go to LOAD.
  - A requester must not wait for ready before asserting valid.
- **LOAD:** exactly one cycle; both strobes = 1 and the captured key/data are driven. Go to WAIT_BUSY.
- **WAIT_BUSY:** on `inCoreBusy == 1` go to RUN.
- **RUN:** on `inCoreBusy == 0` latch `inCoreData` into the response register; `outRspErr = 0`; go to RESP.
- **Watchdog:**
  - Counts cycles spent in WAIT_BUSY plus RUN.
  - When the count reaches `TIMEOUT_CYCLES`: response data = 0, `outRspErr = 1`, `outErr <= 1`, go to RESP.
  - The counter clears on LOAD.
- **RESP:** `outRspValid[owner] = 1`, with data and err held stable.
  - On `inRspReady[owner]`, go to IDLE.
  - Increment `outDoneCnt` when err = 0; wrap from all-ones to 0.
  - The other requester's `inRspReady` is ignored.
- Only one operation is in flight at a time; no request is accepted outside IDLE.
- Key/data outputs to the core hold their last captured value outside LOAD; the core ignores them without a strobe.

## Timing
- **Reset values:** state IDLE, `rr = 0`, `outReqReady = 0`, `outRspValid = 0`, both strobes 0, `outCoreKey = outCoreData = outRspData = 0`, `outRspErr = 0`, `outErr = 0`, `outDoneCnt = 0`, watchdog 0.
- **Cycle sequence:** accept at T; strobes at T+1; `inCoreBusy` seen high at T+2 or T+3; the response is valid the cycle after busy is seen low.
- **Latency:** request-to-response = core busy length + 3 cycles (busy rising at T+2).
- **Back-to-back:** the earliest next accept is the cycle after the response handshake.
- **Reset mid-operation:** returns to IDLE and drops any pending response. The core has no reset, so IDLE must not grant while `inCoreBusy == 1`; the stale core result is discarded.
- **Simultaneous valids:** arbitration is strictly alternating; `rr` advances only on a grant.

## Structure
- Shared package `gift_pkg`:
  - FSM state enum.
  - `GIFT_BLK_W = 128` constant.
  - Default `TIMEOUT_CYCLES`.
- Sub-module `gift_rr_arb2`: two-input round-robin grant with the `rr` pointer register and an update enable.
- The top level instantiates the arbiter and the FSM. The `GiftFullEnc` core itself is instantiated one level up.

## Test plan
- **Single request:** requester 0 sends key = 0, pt = 0 → `outRspValid = 01`, `outRspData` equals the `GiftFullEnc` golden output for the all-zero vector, `outDoneCnt = 1`, latency = busy length + 3.
- **Both requesters valid at once,** four requests each (key = pt = `fedcba9876543210fedcba9876543210`) → grants alternate 0,1,0,1,…, each response goes to the correct owner, `outDoneCnt = 8`.
- **Response backpressure:** hold `inRspReady = 0` for 10 cycles → `outRspValid` and `outRspData` stay stable; no new `outReqReady` is asserted; completion follows on release.
- **Core stub never raises busy,** `TIMEOUT_CYCLES = 8` → RESP 8 cycles after LOAD with `outRspErr = 1`, data 0, `outErr = 1`; `outDoneCnt` unchanged.
- **Reset asserted while in RUN,** core still busy → all outputs at reset values; no grant until `inCoreBusy` falls, then a new request completes correctly.
- **Counter wrap:** `CNT_W = 2` with five requests → `outDoneCnt` reads 1, 2, 3, 0, 1.
